// File: rtl/fir_coeff_bank_ctrl.sv
// rtl/fir_coeff_bank_ctrl.sv - shadow/active coefficient bank controller for a 16-tap FIR
//
// Purpose: accepts a coefficient set over a valid/ready stream into a shadow bank,
// then copies the whole shadow bank into the active bank on a sample boundary.
// Because the copy is a single-cycle update of every tap, the FIR never computes
// with a mix of old and new taps.
//
// Ports:
//   clk         rising-edge system clock
//   rst         synchronous active-high reset
//   start_load  one-cycle request to begin loading a new set
//   cfg_valid   cfg_data / cfg_last valid
//   cfg_ready   word accepted this cycle (high only while loading)
//   cfg_data    coefficient word; word k is tap k
//   cfg_last    final word of a set
//   sample_tick FIR sample-boundary strobe
//   coeff_out   active bank, tap i at bits [W*i +: W]
//   busy        controller is not idle
//   swap_done   one-cycle pulse after the active bank is updated
//   cfg_err     one-cycle pulse when a short or long set is aborted
module fir_coeff_bank_ctrl #(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_load,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [W-1:0]   cfg_data,
    input  logic           cfg_last,
    input  logic           sample_tick,
    output logic [N*W-1:0] coeff_out,
    output logic           busy,
    output logic           swap_done,
    output logic           cfg_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  wr_idx;
    logic [W-1:0]   shadow [N];
    logic [W-1:0]   active [N];

    logic           xfer;
    logic           at_last_idx;
    logic           bad_set;
    logic           do_swap;

    // Power-on / reset coefficient set; taps beyond the 16 listed are zero.
    function automatic logic [W-1:0] default_coeff(input int i);
        case (i)
            0:       default_coeff = W'(512);
            1:       default_coeff = W'(1024);
            2:       default_coeff = W'(2048);
            3:       default_coeff = W'(4096);
            4:       default_coeff = W'(8192);
            5:       default_coeff = W'(4096);
            6:       default_coeff = W'(2048);
            7:       default_coeff = W'(1024);
            8:       default_coeff = W'(512);
            9:       default_coeff = W'(256);
            10:      default_coeff = W'(128);
            11:      default_coeff = W'(64);
            12:      default_coeff = W'(32);
            13:      default_coeff = W'(16);
            14:      default_coeff = W'(8);
            15:      default_coeff = W'(4);
            default: default_coeff = '0;
        endcase
    endfunction

    assign at_last_idx = (wr_idx == IW'(N - 1));
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        xfer      = 1'b0;
        bad_set   = 1'b0;
        do_swap   = 1'b0;
        case (state)
            IDLE: begin
                if (start_load) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                xfer      = cfg_valid;
                if (cfg_valid) begin
                    if (cfg_last && at_last_idx) begin
                        state_nxt = ARMED;
                    end else if (cfg_last || at_last_idx) begin
                        // Short set (early last) or long set (no last on word N-1).
                        bad_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            ARMED: begin
                if (sample_tick) begin
                    do_swap   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx    <= '0;
            swap_done <= 1'b0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
                active[i] <= default_coeff(i);
            end
        end else begin
            swap_done <= do_swap;
            cfg_err   <= bad_set;
            if (state == IDLE && start_load) begin
                wr_idx <= '0;
            end else if (xfer && !at_last_idx) begin
                // The set always ends at index N-1, so the index never wraps.
                wr_idx <= wr_idx + 1'b1;
            end
            if (xfer) begin
                shadow[wr_idx] <= cfg_data;
            end
            if (do_swap) begin
                for (int i = 0; i < N; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    always_comb begin
        coeff_out = '0;
        for (int i = 0; i < N; i++) begin
            coeff_out[W*i +: W] = active[i];
        end
    end

endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// tb/tb_fir_coeff_bank_ctrl.sv - self-checking bench for fir_coeff_bank_ctrl
module tb_fir_coeff_bank_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_load = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [15:0]  cfg_data = '0;
    logic         cfg_last = 1'b0;
    logic         sample_tick = 1'b0;
    logic [255:0] coeff_out;
    logic         busy;
    logic         swap_done;
    logic         cfg_err;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    int swap_cnt = 0;
    int err_cnt = 0;
    int ready_cnt = 0;

    always #5 clk = ~clk;

    fir_coeff_bank_ctrl #(.N(16), .W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_load  (start_load),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_last    (cfg_last),
        .sample_tick (sample_tick),
        .coeff_out   (coeff_out),
        .busy        (busy),
        .swap_done   (swap_done),
        .cfg_err     (cfg_err)
    );

    // Transaction-level model: words collected in a queue, set judged by its length.
    int          m_mode = 0;   // 0 idle, 1 collecting words, 2 waiting for sample tick
    logic [15:0] m_q[$];
    logic [15:0] m_active[16];
    bit          m_swap = 1'b0;
    bit          m_err = 1'b0;
    int          def_set[16] = '{512, 1024, 2048, 4096, 8192, 4096, 2048, 1024,
                                 512, 256, 128, 64, 32, 16, 8, 4};

    always @(posedge clk) begin
        m_swap = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_mode = 0;
            m_q.delete();
            for (int i = 0; i < 16; i++) m_active[i] = 16'(def_set[i]);
        end else begin
            case (m_mode)
                0: if (start_load) begin
                    m_mode = 1;
                    m_q.delete();
                end
                1: if (cfg_valid) begin
                    m_q.push_back(cfg_data);
                    if (cfg_last) begin
                        if (m_q.size() == 16) m_mode = 2;
                        else begin m_err = 1'b1; m_mode = 0; end
                    end else if (m_q.size() == 16) begin
                        m_err = 1'b1;
                        m_mode = 0;
                    end
                end
                default: if (sample_tick) begin
                    for (int i = 0; i < 16; i++) m_active[i] = m_q[i];
                    m_swap = 1'b1;
                    m_mode = 0;
                end
            endcase
        end
    end

    function automatic logic [255:0] model_flat();
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = m_active[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("coeff_out", coeff_out, model_flat());
            chk("busy", 256'(busy), 256'(m_mode != 0));
            chk("cfg_ready", 256'(cfg_ready), 256'(m_mode == 1));
            chk("swap_done", 256'(swap_done), 256'(m_swap));
            chk("cfg_err", 256'(cfg_err), 256'(m_err));
            if (swap_done) swap_cnt++;
            if (cfg_err) err_cnt++;
            if (cfg_ready) ready_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
    endtask

    task automatic send_set(input int n, input int last_at, input bit gaps,
                            input int base, input int step, input bit tick_on_last);
        for (int k = 0; k < n; k++) begin
            cfg_valid   = 1'b1;
            cfg_data    = 16'(base + step * k);
            cfg_last    = (k == last_at);
            sample_tick = tick_on_last && (k == n - 1);
            tick();
            if (gaps && k != n - 1) begin
                cfg_valid = 1'b0;
                cfg_last  = 1'b0;
                tick();
            end
        end
        cfg_valid   = 1'b0;
        cfg_last    = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
    endtask

    int s0;
    int e0;

    initial begin
        // Reset and idle hold
        tick();
        check_en = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("default_tap4", coeff_out[79:64], 256'd8192);
        chk("default_tap15", coeff_out[255:240], 256'd4);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_ready", 256'(cfg_ready), 256'd0);

        // Full load, valid held high, tick three cycles later
        ready_cnt = 0;
        s0 = swap_cnt;
        do_start();
        send_set(16, 15, 1'b0, 100, 100, 1'b0);
        tick();
        tick();
        chk("pre_swap_tap0", coeff_out[15:0], 256'd512);
        pulse_tick();
        chk("swap_tap0", coeff_out[15:0], 256'd100);
        chk("swap_tap15", coeff_out[255:240], 256'd1600);
        chk("swap_busy_low", 256'(busy), 256'd0);
        tick();
        tick();
        chk("ready_cycles", 256'(ready_cnt), 256'd16);
        chk("swap_once", 256'(swap_cnt - s0), 256'd1);

        // Valid toggling during load
        ready_cnt = 0;
        do_start();
        send_set(16, 15, 1'b1, 100, 100, 1'b0);
        tick();
        pulse_tick();
        chk("gap_tap0", coeff_out[15:0], 256'd100);
        chk("gap_tap9", coeff_out[159:144], 256'd1000);
        chk("gap_ready_cycles", 256'(ready_cnt), 256'd31);
        tick();

        // Short set: last on word 9
        s0 = swap_cnt;
        e0 = err_cnt;
        do_start();
        send_set(10, 9, 1'b0, 7, 7, 1'b0);
        tick();
        pulse_tick();
        tick();
        chk("short_err_once", 256'(err_cnt - e0), 256'd1);
        chk("short_no_swap", 256'(swap_cnt - s0), 256'd0);
        chk("short_keep_tap0", coeff_out[15:0], 256'd100);

        // Long set, then a good set with negative taps to confirm restart at tap 0
        e0 = err_cnt;
        do_start();
        send_set(16, -1, 1'b0, 9, 9, 1'b0);
        tick();
        pulse_tick();
        chk("long_err_once", 256'(err_cnt - e0), 256'd1);
        chk("long_no_swap", 256'(swap_cnt - s0), 256'd0);
        do_start();
        send_set(16, 15, 1'b0, -3, -3, 1'b0);
        pulse_tick();
        chk("restart_tap0", coeff_out[15:0], 256'hFFFD);
        chk("restart_tap15", coeff_out[255:240], 256'hFFD0);
        tick();

        // sample_tick coincident with the last word
        s0 = swap_cnt;
        do_start();
        send_set(16, 15, 1'b0, 1000, 1, 1'b1);
        tick();
        chk("coinc_no_swap", 256'(swap_cnt - s0), 256'd0);
        chk("coinc_busy", 256'(busy), 256'd1);
        pulse_tick();
        chk("coinc_swap_tap0", coeff_out[15:0], 256'd1000);
        chk("coinc_swap_tap15", coeff_out[255:240], 256'd1015);
        tick();

        // Reset while armed
        s0 = swap_cnt;
        e0 = err_cnt;
        do_start();
        send_set(16, 15, 1'b0, 50, 2, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pulse_tick();
        tick();
        chk("rst_default_tap4", coeff_out[79:64], 256'd8192);
        chk("rst_default_tap0", coeff_out[15:0], 256'd512);
        chk("rst_no_swap", 256'(swap_cnt - s0), 256'd0);
        chk("rst_no_err", 256'(err_cnt - e0), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
